mult_share_ctrl: RTL and testbench

- Shares one combinational `signed_array_mplier` (N-bit signed × N-bit signed → 2N-bit product) among NREQ requesters.
- Round-robin arbitration with valid/ready handshakes on both the request and response channels.
- Treats the multiplier as a multicycle path: operands are held in registers for MCYC cycles before the product is captured.
- Sits between the arithmetic clients and the shared multiplier instance.

---
 rtl/mult_ctrl_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/signed_array_mplier.sv | 19 +
 rtl/mult_share_ctrl.sv | 148 ++++++++++++++
 tb/tb_mult_share_ctrl.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the multiplier-sharing controller: FSM state
// encoding and the width helper used for requester ids and counters.
package mult_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to index n items, never less than one bit.
  function automatic int calc_idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin arbiter. The search starts at the
// requester after last_grant_i and wraps modulo NREQ; the first requester
// found with its request bit set wins.
module rr_arbiter
  import mult_ctrl_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = calc_idw(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_grant_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  grant_idx_o,
  output logic            grant_any_o
);

  int idx;

  // Rotating priority search: one-hot grant, its index, and a found flag.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    grant_o     = '0;
    grant_idx_o = '0;
    grant_any_o = 1'b0;
    idx         = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(last_grant_i) + off) % NREQ;
      if (!grant_any_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        grant_idx_o  = IDW'(idx);
        grant_any_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/signed_array_mplier.sv
// Combinational N x N signed multiplier producing the full 2N-bit product.
// Both operands are sign-extended to 2N bits so the truncated 2N-bit
// product is exact, including the min x min case.
module signed_array_mplier #(
  parameter int N = 32
) (
  input  logic [N-1:0]   mplier,
  input  logic [N-1:0]   mcand,
  output logic [2*N-1:0] product
);

  logic signed [2*N-1:0] mplier_ext;
  logic signed [2*N-1:0] mcand_ext;

  assign mplier_ext = {{N{mplier[N-1]}}, mplier};
  assign mcand_ext  = {{N{mcand[N-1]}}, mcand};
  assign product    = mplier_ext * mcand_ext;

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one combinational signed multiplier among NREQ requesters.
// A round-robin arbiter picks one request per IDLE cycle; the operands are
// then held in registers for MCYC cycles (multicycle path through the
// multiplier) before the product is captured and offered on the response
// channel until the consumer takes it.
module mult_share_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int N    = 32,
  parameter int NREQ = 2,
  parameter int MCYC = 2,
  parameter int IDW  = calc_idw(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_mplier,
  input  logic [NREQ*N-1:0] req_mcand,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*N-1:0]    rsp_product,
  output logic              busy
);

  // Counter must hold MCYC-1; sized from MCYC+1 so MCYC=1 still gets a bit.
  localparam int CNTW = calc_idw(MCYC + 1);

  state_e          state_q, state_d;
  logic [N-1:0]    op_mplier_q, op_mplier_d;
  logic [N-1:0]    op_mcand_q, op_mcand_d;
  logic [2*N-1:0]  product_q, product_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  last_grant_q, last_grant_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [NREQ-1:0] grant_oh;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;
  logic [N-1:0]    sel_mplier;
  logic [N-1:0]    sel_mcand;
  logic [2*N-1:0]  mult_out;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant_oh),
    .grant_idx_o  (grant_idx),
    .grant_any_o  (grant_any)
  );

  // The op registers are the only multiplier inputs, so they stay constant
  // for the whole CALC window.
  signed_array_mplier #(
    .N (N)
  ) u_mplier (
    .mplier  (op_mplier_q),
    .mcand   (op_mcand_q),
    .product (mult_out)
  );

  // Operand slice of the granted requester.
  always_comb begin
    sel_mplier = '0;
    sel_mcand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_oh[i]) begin
        sel_mplier = req_mplier[i*N +: N];
        sel_mcand  = req_mcand[i*N +: N];
      end
    end
  end

  // Next-state and request-side handshake; everything holds by default.
  always_comb begin
    state_d      = state_q;
    op_mplier_d  = op_mplier_q;
    op_mcand_d   = op_mcand_q;
    product_d    = product_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    req_ready    = '0;

    case (state_q)
      IDLE: begin
        // Ready goes only to the granted, valid requester, so a grant is
        // already a completed handshake at the coming edge.
        req_ready = grant_oh;
        if (grant_any) begin
          op_mplier_d  = sel_mplier;
          op_mcand_d   = sel_mcand;
          id_d         = grant_idx;
          last_grant_d = grant_idx;
          cnt_d        = CNTW'(MCYC - 1);
          state_d      = CALC;
        end
      end
      CALC: begin
        if (cnt_q == '0) begin
          product_d = mult_out;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      op_mplier_q  <= '0;
      op_mcand_q   <= '0;
      product_q    <= '0;
      id_q         <= '0;
      last_grant_q <= IDW'(NREQ - 1);
      cnt_q        <= '0;
    end else begin
      // NOTE: registers are updated with non-blocking assignments so every
      // flop samples the pre-edge values regardless of statement order.
      state_q      <= state_d;
      op_mplier_q  <= op_mplier_d;
      op_mcand_q   <= op_mcand_d;
      product_q    <= product_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign rsp_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign rsp_id      = id_q;
  assign rsp_product = product_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Scoreboard bench for mult_share_ctrl: the driver pushes the expected
// response when a request handshake happens; an independent monitor pops
// and compares whenever a response handshake is presented.
module tb_mult_share_ctrl;

  localparam int N    = 32;
  localparam int NREQ = 2;
  localparam int MCYC = 2;
  localparam int IDW  = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_mplier;
  logic [NREQ*N-1:0] req_mcand;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [2*N-1:0]    rsp_product;
  logic              busy;

  always #5 clk = ~clk;

  mult_share_ctrl #(
    .N    (N),
    .NREQ (NREQ),
    .MCYC (MCYC),
    .IDW  (IDW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_mplier  (req_mplier),
    .req_mcand   (req_mcand),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] p;
  } op_t;

  typedef struct {
    int             id;
    logic [2*N-1:0] p;
  } exp_t;

  op_t  pend0[$];
  op_t  pend1[$];
  op_t  cur[NREQ];
  logic v[NREQ];
  exp_t sb_q[$];
  int   exp_grant[$];
  logic rdy_v;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic op_t mk(input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic [2*N-1:0] p);
    op_t o;
    o.a = a;
    o.b = b;
    o.p = p;
    return o;
  endfunction

  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a,
                                             input logic [N-1:0] b);
    longint x;
    longint y;
    x = $signed(a);
    y = $signed(b);
    return x * y;
  endfunction

  // One clock of request-side driving: load pending ops, drive at the
  // falling edge, then look for a handshake that the next rising edge takes.
  task automatic step();
    @(negedge clk);
    if (!v[0] && pend0.size() > 0) begin cur[0] = pend0.pop_front(); v[0] = 1'b1; end
    if (!v[1] && pend1.size() > 0) begin cur[1] = pend1.pop_front(); v[1] = 1'b1; end
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]        = v[i];
      req_mplier[i*N +: N] = cur[i].a;
      req_mcand[i*N +: N]  = cur[i].b;
    end
    rsp_ready = rdy_v;
    #1;
    check(($countones(req_ready) <= 1) && ((req_ready & ~req_valid) == '0),
          "ready_onehot", 64'(req_ready), 64'(req_valid));
    for (int i = 0; i < NREQ; i++) begin
      if (v[i] && req_ready[i]) begin
        int g;
        sb_q.push_back('{id: i, p: cur[i].p});
        if (exp_grant.size() > 0) begin
          g = exp_grant.pop_front();
          check(i == g, "grant_order", 64'(i), 64'(g));
        end
        v[i] = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int budget;
    budget = 3000;
    while ((pend0.size() > 0 || pend1.size() > 0 || v[0] || v[1] ||
            sb_q.size() > 0) && budget > 0) begin
      step();
      budget--;
    end
    check(budget > 0, "drain_timeout", 64'(sb_q.size()), 64'd0);
    check(exp_grant.size() == 0, "grants_missing", 64'(exp_grant.size()), 64'd0);
    exp_grant.delete();
  endtask

  task automatic clear_bench();
    pend0.delete();
    pend1.delete();
    sb_q.delete();
    exp_grant.delete();
    for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
  endtask

  // Monitor: compare each response as it is handed over.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && rsp_valid && rsp_ready) begin
        check(sb_q.size() > 0, "unexpected_rsp", rsp_product, 64'd0);
        if (sb_q.size() > 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check(rsp_id == IDW'(e.id), "rsp_id", 64'(rsp_id), 64'(e.id));
          check(rsp_product == e.p, "rsp_product", rsp_product, e.p);
        end
      end
    end
  end

  initial begin
    int budget;
    logic [N-1:0] ra;
    logic [N-1:0] rb;

    rst        = 1'b1;
    req_valid  = '0;
    req_mplier = '0;
    req_mcand  = '0;
    rsp_ready  = 1'b0;
    rdy_v      = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      v[i]   = 1'b0;
      cur[i] = mk('0, '0, '0);
    end

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check(rsp_valid == 1'b0, "rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check(busy == 1'b0, "rst_busy", 64'(busy), 64'd0);
    check(req_ready == '0, "rst_req_ready", 64'(req_ready), 64'd0);
    check(rsp_id == '0, "rst_rsp_id", 64'(rsp_id), 64'd0);
    check(rsp_product == '0, "rst_rsp_product", rsp_product, 64'd0);
    rst = 1'b0;

    // Single request and latency: 3 x -5.
    pend0.push_back(mk(32'd3, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1));
    exp_grant.push_back(0);
    step();
    check(req_ready == 2'b01, "t1_ready", 64'(req_ready), 64'd1);
    step();
    check(rsp_valid == 1'b0 && busy == 1'b1, "lat_k1", 64'(rsp_valid), 64'd0);
    step();
    check(rsp_valid == 1'b0, "lat_k2", 64'(rsp_valid), 64'd0);
    step();
    check(rsp_valid == 1'b1, "lat_k3", 64'(rsp_valid), 64'd1);
    drain();

    // Both requesters valid right after reset.
    @(negedge clk);
    rst = 1'b1;
    clear_bench();
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pend0.push_back(mk(32'd7, 32'd6, 64'd42));
    pend1.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1));
    exp_grant.push_back(0);
    exp_grant.push_back(1);
    drain();

    // Fairness with both continuously valid.
    pend0.push_back(mk(32'd2, 32'd3, 64'd6));
    pend1.push_back(mk(32'hFFFF_FFF9, 32'hFFFF_FFF8, 64'd56));
    pend0.push_back(mk(32'hFFFF_FFFC, 32'd5, 64'hFFFF_FFFF_FFFF_FFEC));
    pend1.push_back(mk(32'd9, 32'hFFFF_FFF7, 64'hFFFF_FFFF_FFFF_FFAF));
    pend0.push_back(mk(32'd100, 32'd100, 64'd10000));
    pend1.push_back(mk(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000));
    for (int k = 0; k < 6; k++) exp_grant.push_back(k % 2);
    drain();

    // Arithmetic corners.
    pend0.push_back(mk(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000));
    pend0.push_back(mk(32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000));
    pend0.push_back(mk(32'h0000_0000, 32'hFFFF_FFFF, 64'd0));
    drain();

    // Backpressure: result held in DONE while rsp_ready is low.
    rdy_v = 1'b0;
    pend0.push_back(mk(32'd123, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FF0A));
    budget = 20;
    while (!rsp_valid && budget > 0) begin
      step();
      budget--;
    end
    check(budget > 0, "bp_valid_timeout", 64'(rsp_valid), 64'd1);
    pend1.push_back(mk(32'd10, 32'd11, 64'd110));
    exp_grant.push_back(1);
    for (int k = 0; k < 5; k++) begin
      step();
      check(rsp_valid == 1'b1, "bp_valid", 64'(rsp_valid), 64'd1);
      check(rsp_product == 64'hFFFF_FFFF_FFFF_FF0A, "bp_product", rsp_product,
            64'hFFFF_FFFF_FFFF_FF0A);
      check(rsp_id == 1'b0, "bp_id", 64'(rsp_id), 64'd0);
      check(req_ready == '0, "bp_no_ready", 64'(req_ready), 64'd0);
    end
    rdy_v = 1'b1;
    step();
    check(req_ready == '0, "bp_done_cycle", 64'(req_ready), 64'd0);
    step();
    check(req_ready == 2'b10, "bp_next_grant", 64'(req_ready), 64'd2);
    drain();

    // Reset in the middle of CALC.
    pend0.push_back(mk(32'd5, 32'd5, 64'd25));
    step();
    check(req_ready == 2'b01, "mid_accept", 64'(req_ready), 64'd1);
    step();
    rst = 1'b1;
    #1;
    check(rsp_valid == 1'b0, "mid_rsp_valid", 64'(rsp_valid), 64'd0);
    check(busy == 1'b0, "mid_busy", 64'(busy), 64'd0);
    check(req_ready == '0, "mid_req_ready", 64'(req_ready), 64'd0);
    check(rsp_product == '0, "mid_product", rsp_product, 64'd0);
    check(rsp_id == '0, "mid_id", 64'(rsp_id), 64'd0);
    clear_bench();
    repeat (3) begin
      step();
      check(rsp_valid == 1'b0, "mid_no_rsp", 64'(rsp_valid), 64'd0);
    end
    rst = 1'b0;
    pend0.push_back(mk(32'hFFFF_FFFD, 32'd4, 64'hFFFF_FFFF_FFFF_FFF4));
    pend1.push_back(mk(32'd6, 32'hFFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFDC));
    exp_grant.push_back(0);
    exp_grant.push_back(1);
    drain();

    // Random operands against a behavioural signed multiply.
    for (int k = 0; k < 100; k++) begin
      ra = $urandom;
      rb = $urandom;
      if (k % 2 == 0) pend0.push_back(mk(ra, rb, ref_mul(ra, rb)));
      else            pend1.push_back(mk(ra, rb, ref_mul(ra, rb)));
    end
    drain();

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
